// File: rtl/rs_simple_pkg.sv
// Shared widths and entry field positions for the simple-op reservation station.
// Allocation targets tell each dispatch lane which slot (if any) it lands in.
package rs_simple_pkg;

    localparam int ENTRY_W      = 114;
    localparam int TAG_W        = 4;
    localparam int DATA_W       = 32;

    localparam int RD_LSB       = 0;
    localparam int RD_MSB       = 4;
    localparam int S1_VALID_BIT = 5;
    localparam int S1_LSB       = 6;
    localparam int S2_VALID_BIT = 38;
    localparam int S2_LSB       = 39;
    localparam int REGWRITE_BIT = 71;
    localparam int CTRL_LSB     = 72;
    localparam int ALUOP_LSB    = 76;
    localparam int ALUOP_MSB    = 81;
    localparam int UPPER_LSB    = 82;

    typedef enum logic [1:0] {
        ALLOC_NONE  = 2'd0,
        ALLOC_SLOT0 = 2'd1,
        ALLOC_SLOT1 = 2'd2
    } alloc_e;

endpackage

// File: rtl/rs_simple_slot.sv
// One reservation-station slot: holds an entry and its ROB number, and captures
// CDB results for waiting sources, including on the entry being loaded this cycle.
module rs_simple_slot #(
    parameter int ENTRY_W = rs_simple_pkg::ENTRY_W,
    parameter int TAG_W   = rs_simple_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [ENTRY_W-1:0] load_entry,
    input  logic [TAG_W-1:0]   load_num,
    input  logic               issue,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_rob_num,
    input  logic [31:0]        cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_rob_num,
    input  logic [31:0]        cdb1_data,
    output logic [ENTRY_W-1:0] entry,
    output logic [TAG_W-1:0]   entry_num,
    output logic               occupied,
    output logic               occupied_next
);
    import rs_simple_pkg::*;

    logic               occ_q, occ_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [TAG_W-1:0]   num_q, num_d;
    logic [ENTRY_W-1:0] src_entry;
    logic [ENTRY_W-1:0] woken_s1;
    logic [ENTRY_W-1:0] woken;

    // cdb0 is checked first so it wins when both buses carry the awaited tag.
    function automatic logic [ENTRY_W-1:0] wake_src(
        input logic [ENTRY_W-1:0] e,
        input int                 vbit,
        input int                 lsb,
        input logic               c0v,
        input logic [TAG_W-1:0]   c0t,
        input logic [31:0]        c0d,
        input logic               c1v,
        input logic [TAG_W-1:0]   c1t,
        input logic [31:0]        c1d
    );
        logic [ENTRY_W-1:0] r;
        logic [TAG_W-1:0]   tag;
        r   = e;
        tag = e[lsb +: TAG_W];
        if (!e[vbit]) begin
            if (c0v && (c0t == tag)) begin
                r[lsb +: DATA_W] = c0d;
                r[vbit]          = 1'b1;
            end else if (c1v && (c1t == tag)) begin
                r[lsb +: DATA_W] = c1d;
                r[vbit]          = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        src_entry = load ? load_entry : entry_q;
        woken_s1  = wake_src(src_entry, S1_VALID_BIT, S1_LSB,
                             cdb0_valid, cdb0_rob_num, cdb0_data,
                             cdb1_valid, cdb1_rob_num, cdb1_data);
        woken     = wake_src(woken_s1, S2_VALID_BIT, S2_LSB,
                             cdb0_valid, cdb0_rob_num, cdb0_data,
                             cdb1_valid, cdb1_rob_num, cdb1_data);

        occ_d   = occ_q;
        entry_d = entry_q;
        num_d   = num_q;
        // An empty slot always stores zeros so it can never look ready.
        if (flush || (issue && occ_q)) begin
            occ_d   = 1'b0;
            entry_d = '0;
            num_d   = '0;
        end else if (load) begin
            occ_d   = 1'b1;
            entry_d = woken;
            num_d   = load_num;
        end else if (occ_q) begin
            entry_d = woken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 1'b0;
            entry_q <= '0;
            num_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            entry_q <= entry_d;
            num_q   <= num_d;
        end
    end

    assign entry         = entry_q;
    assign entry_num     = num_q;
    assign occupied      = occ_q;
    assign occupied_next = occ_d;

endmodule

// File: rtl/rs_simple.sv
// Two-slot reservation station for simple ops: two dispatch lanes, two CDB buses,
// per-slot issue. Slot allocation, free count and newest-slot selector live here.
module rs_simple #(
    parameter int ENTRY_W = rs_simple_pkg::ENTRY_W,
    parameter int TAG_W   = rs_simple_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               dispatch0_valid,
    input  logic               dispatch1_valid,
    input  logic [ENTRY_W-1:0] dispatch0_entry,
    input  logic [ENTRY_W-1:0] dispatch1_entry,
    input  logic [TAG_W-1:0]   dispatch0_rob_num,
    input  logic [TAG_W-1:0]   dispatch1_rob_num,
    output logic [1:0]         free_count,
    input  logic               cdb0_valid,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb0_rob_num,
    input  logic [TAG_W-1:0]   cdb1_rob_num,
    input  logic [31:0]        cdb0_data,
    input  logic [31:0]        cdb1_data,
    output logic [ENTRY_W-1:0] rs_simple_0,
    output logic [ENTRY_W-1:0] rs_simple_1,
    output logic [TAG_W-1:0]   rs_simple_0_entry_num,
    output logic [TAG_W-1:0]   rs_simple_1_entry_num,
    output logic               selector,
    input  logic               simple_0_issue,
    input  logic               simple_1_issue
);
    import rs_simple_pkg::*;

    alloc_e             lane0_slot, lane1_slot;
    logic               occ0, occ1, occ0_next, occ1_next;
    logic               load0, load1;
    logic [ENTRY_W-1:0] load0_entry, load1_entry;
    logic [TAG_W-1:0]   load0_num, load1_num;
    logic               selector_q, selector_d;
    logic [1:0]         free_count_q, free_count_d;

    // Allocation looks only at occupancy at cycle start, so a slot freed by
    // issue this cycle cannot be refilled until the next one.
    always_comb begin
        lane0_slot = ALLOC_NONE;
        lane1_slot = ALLOC_NONE;
        if (dispatch0_valid) begin
            if (!occ0)      lane0_slot = ALLOC_SLOT0;
            else if (!occ1) lane0_slot = ALLOC_SLOT1;
        end
        if (dispatch1_valid) begin
            if (lane0_slot == ALLOC_SLOT0) begin
                if (!occ1) lane1_slot = ALLOC_SLOT1;
            end else if (lane0_slot == ALLOC_NONE) begin
                if (!occ0)      lane1_slot = ALLOC_SLOT0;
                else if (!occ1) lane1_slot = ALLOC_SLOT1;
            end
        end

        load0       = (lane0_slot == ALLOC_SLOT0) || (lane1_slot == ALLOC_SLOT0);
        load1       = (lane0_slot == ALLOC_SLOT1) || (lane1_slot == ALLOC_SLOT1);
        load0_entry = (lane0_slot == ALLOC_SLOT0) ? dispatch0_entry   : dispatch1_entry;
        load0_num   = (lane0_slot == ALLOC_SLOT0) ? dispatch0_rob_num : dispatch1_rob_num;
        load1_entry = (lane0_slot == ALLOC_SLOT1) ? dispatch0_entry   : dispatch1_entry;
        load1_num   = (lane0_slot == ALLOC_SLOT1) ? dispatch0_rob_num : dispatch1_rob_num;
    end

    always_comb begin
        selector_d = selector_q;
        if (load0 && load1)      selector_d = (lane1_slot == ALLOC_SLOT1);
        else if (load0 && occ1)  selector_d = 1'b0;
        else if (load1 && occ0)  selector_d = 1'b1;
        if (!occ0_next && !occ1_next) selector_d = 1'b0;
        free_count_d = {1'b0, ~occ0_next} + {1'b0, ~occ1_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selector_q   <= 1'b0;
            free_count_q <= 2'd2;
        end else begin
            selector_q   <= selector_d;
            free_count_q <= free_count_d;
        end
    end

    rs_simple_slot #(.ENTRY_W(ENTRY_W), .TAG_W(TAG_W)) u_slot0 (
        .clk(clk), .rst(rst), .flush(flush),
        .load(load0), .load_entry(load0_entry), .load_num(load0_num),
        .issue(simple_0_issue),
        .cdb0_valid(cdb0_valid), .cdb0_rob_num(cdb0_rob_num), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_rob_num(cdb1_rob_num), .cdb1_data(cdb1_data),
        .entry(rs_simple_0), .entry_num(rs_simple_0_entry_num),
        .occupied(occ0), .occupied_next(occ0_next)
    );

    rs_simple_slot #(.ENTRY_W(ENTRY_W), .TAG_W(TAG_W)) u_slot1 (
        .clk(clk), .rst(rst), .flush(flush),
        .load(load1), .load_entry(load1_entry), .load_num(load1_num),
        .issue(simple_1_issue),
        .cdb0_valid(cdb0_valid), .cdb0_rob_num(cdb0_rob_num), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_rob_num(cdb1_rob_num), .cdb1_data(cdb1_data),
        .entry(rs_simple_1), .entry_num(rs_simple_1_entry_num),
        .occupied(occ1), .occupied_next(occ1_next)
    );

    assign selector   = selector_q;
    assign free_count = free_count_q;

endmodule

// File: tb/tb_rs_simple.sv
// Directed bench for rs_simple: allocation, wakeup, issue, selector, flush and reset.
module tb_rs_simple;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush;
    logic         d0v, d1v;
    logic [113:0] d0e, d1e;
    logic [3:0]   d0r, d1r;
    logic [1:0]   free_count;
    logic         c0v, c1v;
    logic [3:0]   c0r, c1r;
    logic [31:0]  c0d, c1d;
    logic [113:0] slot0, slot1;
    logic [3:0]   num0, num1;
    logic         selector;
    logic         iss0, iss1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [113:0] ea, eb, ex;

    always #5 clk = ~clk;

    rs_simple dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch0_valid(d0v), .dispatch1_valid(d1v),
        .dispatch0_entry(d0e), .dispatch1_entry(d1e),
        .dispatch0_rob_num(d0r), .dispatch1_rob_num(d1r),
        .free_count(free_count),
        .cdb0_valid(c0v), .cdb1_valid(c1v),
        .cdb0_rob_num(c0r), .cdb1_rob_num(c1r),
        .cdb0_data(c0d), .cdb1_data(c1d),
        .rs_simple_0(slot0), .rs_simple_1(slot1),
        .rs_simple_0_entry_num(num0), .rs_simple_1_entry_num(num1),
        .selector(selector),
        .simple_0_issue(iss0), .simple_1_issue(iss1)
    );

    // Layout: upper[113:82] aluop[81:76] ctrl[75:72] regwrite[71] s2[70:39] s2v[38] s1[37:6] s1v[5] rd[4:0]
    function automatic logic [113:0] mk(input logic [31:0] s1, input logic s1v,
                                        input logic [31:0] s2, input logic s2v,
                                        input logic [4:0] rd);
        return {32'hCAFE_0000 | {27'd0, rd}, 6'h2A, 4'b0101, 1'b1, s2, s2v, s1, s1v, rd};
    endfunction

    task automatic clear_inputs();
        flush = 0; d0v = 0; d1v = 0; d0e = '0; d1e = '0; d0r = '0; d1r = '0;
        c0v = 0; c1v = 0; c0r = '0; c1r = '0; c0d = '0; c1d = '0; iss0 = 0; iss1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        total_cnt++; if (free_count !== 2'd2) $display("FAIL in_reset_free got %0d exp 2", free_count); else pass_cnt++;
        total_cnt++; if (slot0 !== '0 || slot1 !== '0) $display("FAIL in_reset_slots got %h %h exp 0", slot0, slot1); else pass_cnt++;
        rst = 0;
        tick();
        total_cnt++; if (free_count !== 2'd2) $display("FAIL reset_free got %0d exp 2", free_count); else pass_cnt++;
        total_cnt++; if (slot0 !== '0) $display("FAIL reset_slot0 got %h exp 0", slot0); else pass_cnt++;
        total_cnt++; if (slot1 !== '0) $display("FAIL reset_slot1 got %h exp 0", slot1); else pass_cnt++;
        total_cnt++; if (selector !== 1'b0) $display("FAIL reset_sel got %0d exp 0", selector); else pass_cnt++;
        total_cnt++; if (num0 !== 4'd0 || num1 !== 4'd0) $display("FAIL reset_nums got %0d %0d exp 0 0", num0, num1); else pass_cnt++;
    endtask

    task automatic test_dispatch_wakeup();
        ea = mk(32'd5, 1'b1, 32'd3, 1'b0, 5'd9);
        d0v = 1; d0e = ea; d0r = 4'd7;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== ea) $display("FAIL dw_slot0 got %h exp %h", slot0, ea); else pass_cnt++;
        total_cnt++; if (num0 !== 4'd7) $display("FAIL dw_num0 got %0d exp 7", num0); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd1) $display("FAIL dw_free got %0d exp 1", free_count); else pass_cnt++;
        total_cnt++; if (slot1 !== '0) $display("FAIL dw_slot1 got %h exp 0", slot1); else pass_cnt++;
        total_cnt++; if (selector !== 1'b0) $display("FAIL dw_sel got %0d exp 0", selector); else pass_cnt++;
        c1v = 1; c1r = 4'd3; c1d = 32'h10;
        tick(); clear_inputs();
        ex = mk(32'd5, 1'b1, 32'h10, 1'b1, 5'd9);
        total_cnt++; if (slot0 !== ex) $display("FAIL dw_wake got %h exp %h", slot0, ex); else pass_cnt++;
        iss0 = 1;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== '0 || num0 !== 4'd0) $display("FAIL dw_issue got %h/%0d exp 0/0", slot0, num0); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd2) $display("FAIL dw_issue_free got %0d exp 2", free_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ea = mk(32'd11, 1'b1, 32'd12, 1'b1, 5'd1);
        eb = mk(32'd2, 1'b0, 32'd13, 1'b1, 5'd2);
        d0v = 1; d0e = ea; d0r = 4'd1;
        d1v = 1; d1e = eb; d1r = 4'd2;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== ea) $display("FAIL b2b_slot0 got %h exp %h", slot0, ea); else pass_cnt++;
        total_cnt++; if (slot1 !== eb) $display("FAIL b2b_slot1 got %h exp %h", slot1, eb); else pass_cnt++;
        total_cnt++; if (num0 !== 4'd1 || num1 !== 4'd2) $display("FAIL b2b_nums got %0d %0d exp 1 2", num0, num1); else pass_cnt++;
        total_cnt++; if (selector !== 1'b1) $display("FAIL b2b_sel got %0d exp 1", selector); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd0) $display("FAIL b2b_free got %0d exp 0", free_count); else pass_cnt++;
    endtask

    task automatic test_full_issue_drop();
        iss0 = 1; d0v = 1; d0e = mk(32'd1, 1'b1, 32'd1, 1'b1, 5'd3); d0r = 4'd9;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== '0) $display("FAIL drop_slot0 got %h exp 0", slot0); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd1) $display("FAIL drop_free got %0d exp 1", free_count); else pass_cnt++;
        total_cnt++; if (selector !== 1'b1) $display("FAIL drop_sel got %0d exp 1", selector); else pass_cnt++;
        total_cnt++; if (slot1 !== eb) $display("FAIL drop_slot1 got %h exp %h", slot1, eb); else pass_cnt++;
        ea = mk(32'd20, 1'b1, 32'd21, 1'b1, 5'd4);
        d0v = 1; d0e = ea; d0r = 4'd10;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== ea || num0 !== 4'd10) $display("FAIL refill_slot0 got %h/%0d exp %h/10", slot0, num0, ea); else pass_cnt++;
        total_cnt++; if (selector !== 1'b0) $display("FAIL refill_sel got %0d exp 0", selector); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd0) $display("FAIL refill_free got %0d exp 0", free_count); else pass_cnt++;
    endtask

    task automatic test_flush();
        flush = 1; c0v = 1; c0r = 4'd2; c0d = 32'h77;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== '0 || slot1 !== '0) $display("FAIL flush_full got %h %h exp 0", slot0, slot1); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd2 || selector !== 1'b0) $display("FAIL flush_full_state got free %0d sel %0d exp 2 0", free_count, selector); else pass_cnt++;
        flush = 1; d0v = 1; d0e = mk(32'd4, 1'b0, 32'd0, 1'b1, 5'd5); d0r = 4'd3;
        c0v = 1; c0r = 4'd4; c0d = 32'h99;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== '0 || slot1 !== '0) $display("FAIL flush_disp got %h %h exp 0", slot0, slot1); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd2) $display("FAIL flush_disp_free got %0d exp 2", free_count); else pass_cnt++;
    endtask

    task automatic test_race_and_priority();
        d0v = 1; d0e = mk(32'd4, 1'b0, 32'd6, 1'b0, 5'd3); d0r = 4'd5;
        c0v = 1; c0r = 4'd4; c0d = 32'hABCD;
        c1v = 1; c1r = 4'd6; c1d = 32'h55;
        tick(); clear_inputs();
        ex = mk(32'hABCD, 1'b1, 32'h55, 1'b1, 5'd3);
        total_cnt++; if (slot0 !== ex) $display("FAIL race_slot0 got %h exp %h", slot0, ex); else pass_cnt++;
        eb = mk(32'd2, 1'b0, 32'd7, 1'b1, 5'd4);
        d1v = 1; d1e = eb; d1r = 4'd6;
        tick(); clear_inputs();
        total_cnt++; if (slot1 !== eb || num1 !== 4'd6) $display("FAIL lane1_slot1 got %h/%0d exp %h/6", slot1, num1, eb); else pass_cnt++;
        total_cnt++; if (selector !== 1'b1) $display("FAIL lane1_sel got %0d exp 1", selector); else pass_cnt++;
        c0v = 1; c0r = 4'd2; c0d = 32'h111;
        c1v = 1; c1r = 4'd2; c1d = 32'h222;
        tick(); clear_inputs();
        ex = mk(32'h111, 1'b1, 32'd7, 1'b1, 5'd4);
        total_cnt++; if (slot1 !== ex) $display("FAIL cdb_prio got %h exp %h", slot1, ex); else pass_cnt++;
    endtask

    task automatic test_issue_wins();
        iss0 = 1; iss1 = 1;
        tick(); clear_inputs();
        total_cnt++; if (free_count !== 2'd2 || selector !== 1'b0) $display("FAIL issue_both got free %0d sel %0d exp 2 0", free_count, selector); else pass_cnt++;
        d0v = 1; d0e = mk(32'd1, 1'b1, 32'd5, 1'b0, 5'd7); d0r = 4'd3;
        tick(); clear_inputs();
        iss0 = 1; iss1 = 1; c0v = 1; c0r = 4'd5; c0d = 32'h1234;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== '0 || slot1 !== '0) $display("FAIL issue_wake got %h %h exp 0", slot0, slot1); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd2) $display("FAIL issue_wake_free got %0d exp 2", free_count); else pass_cnt++;
    endtask

    task automatic test_lane1_alone();
        ea = mk(32'd30, 1'b1, 32'd31, 1'b1, 5'd10);
        d1v = 1; d1e = ea; d1r = 4'd12;
        tick(); clear_inputs();
        total_cnt++; if (slot0 !== ea || num0 !== 4'd12) $display("FAIL l1only_slot0 got %h/%0d exp %h/12", slot0, num0, ea); else pass_cnt++;
        total_cnt++; if (selector !== 1'b0) $display("FAIL l1only_sel got %0d exp 0", selector); else pass_cnt++;
        eb = mk(32'd40, 1'b1, 32'd41, 1'b1, 5'd11);
        d0v = 1; d0e = eb; d0r = 4'd13;
        d1v = 1; d1e = mk(32'd50, 1'b1, 32'd51, 1'b1, 5'd12); d1r = 4'd14;
        tick(); clear_inputs();
        total_cnt++; if (slot1 !== eb || num1 !== 4'd13) $display("FAIL l0_to_slot1 got %h/%0d exp %h/13", slot1, num1, eb); else pass_cnt++;
        total_cnt++; if (selector !== 1'b1 || free_count !== 2'd0) $display("FAIL l1_drop got sel %0d free %0d exp 1 0", selector, free_count); else pass_cnt++;
        total_cnt++; if (slot0 !== ea) $display("FAIL l1_drop_slot0 got %h exp %h", slot0, ea); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1;
        #1;
        total_cnt++; if (slot0 !== '0 || slot1 !== '0) $display("FAIL async_rst_slots got %h %h exp 0", slot0, slot1); else pass_cnt++;
        total_cnt++; if (free_count !== 2'd2 || selector !== 1'b0) $display("FAIL async_rst_state got free %0d sel %0d exp 2 0", free_count, selector); else pass_cnt++;
        total_cnt++; if (num0 !== 4'd0 || num1 !== 4'd0) $display("FAIL async_rst_nums got %0d %0d exp 0 0", num0, num1); else pass_cnt++;
        #1;
        rst = 0;
        tick();
        total_cnt++; if (free_count !== 2'd2) $display("FAIL post_rst_free got %0d exp 2", free_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dispatch_wakeup();
        test_back_to_back();
        test_full_issue_drop();
        test_flush();
        test_race_and_priority();
        test_issue_wins();
        test_lane1_alone();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
